ram_burst_ctrl: RTL and testbench
=================================

RAM_BURST_CTRL -- requirements
Module: ram_burst_ctrl

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 6, RAM address width (64 words); DATA_W, default 8, RAM word width.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset. The clock port is named clock; the reset port is named rst_n.
REQ-003 Ports SHALL be as follows (name, direction, width, meaning):
- clock  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  burst command offered
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_base  in  ADDR_W  first RAM address
- cmd_len  in  ADDR_W  beats minus 1 (0..63 gives 1..64 beats)
- wr_data  in  DATA_W  write-stream word
- wr_valid  in  1  write word offered
- wr_ready  out  1  write word accepted
- rd_data  out  DATA_W  read-stream word
- rd_valid  out  1  read word offered
- rd_ready  in  1  read word accepted
- done  out  1  one-cycle pulse when a burst completes
- ram_data  out  DATA_W  to RAM data
- ram_addr  out  ADDR_W  to RAM addr
- ram_we  out  1  to RAM we
- ram_q  in  DATA_W  from RAM q

Function
REQ-004 The state machine SHALL have four states: IDLE, WRITE, PRIME, READ.
REQ-005 cmd_ready SHALL be high only in IDLE; a command is accepted on cmd_valid&&cmd_ready, which latches base into ptr and len into cnt.
REQ-006 On acceptance, the FSM SHALL go IDLE->WRITE if cmd_write=1, else IDLE->PRIME.
REQ-007 In WRITE: wr_ready=1; ram_addr=ptr; ram_data=wr_data; ram_we=wr_valid&&wr_ready (combinational).
REQ-008 Each write handshake SHALL increment ptr modulo 2^ADDR_W and decrement cnt.
REQ-009 The write handshake with cnt=0 SHALL end the burst: the next cycle is IDLE with done=1.
REQ-010 ram_we SHALL be 0 in every cycle without a write handshake, including all read states.
REQ-011 The RAM captures its address on the clock edge while we=0, and ram_q reflects that address in the following cycle.
REQ-012 In PRIME: ram_addr=ptr, rd_valid=0, then unconditionally -> READ.
REQ-013 In READ: rd_valid=1; rd_data=ram_q (combinational pass-through).
REQ-014 In READ, ram_addr SHALL be ptr+1 when rd_ready=1 and ptr otherwise, so that a stall re-captures the same address and rd_data holds stable.
REQ-015 Each read handshake SHALL increment ptr modulo 2^ADDR_W and decrement cnt.
REQ-016 The read handshake with cnt=0 SHALL end the burst: the next cycle is IDLE with done=1, and rd_valid=0 in that cycle.
REQ-017 Read latency SHALL be: command accepted at cycle N, first rd_valid at cycle N+2. Sustained throughput SHALL be 1 beat per cycle in both directions.
REQ-018 Addresses SHALL wrap from 2^ADDR_W-1 to 0 within a burst; a 64-beat burst from any base touches every word exactly once.
REQ-019 cmd_valid SHALL be ignored outside IDLE, and no command is accepted in the cycle done is high.
REQ-020 wr_valid SHALL be ignored outside WRITE; rd_ready SHALL be ignored outside READ.
REQ-021 In IDLE: ram_we=0, ram_addr=0, ram_data=0, wr_ready=0, rd_valid=0.

Reset
REQ-022 Assertion of rst_n=0 SHALL immediately force IDLE, ptr=0, cnt=0, done=0, and all outputs to 0 except cmd_ready.
REQ-023 cmd_ready SHALL be 1 from the first clock edge after rst_n deasserts.
REQ-024 Reset mid-burst SHALL abandon the burst with no done pulse. RAM contents are not cleared and words already written remain.
REQ-025 Deassertion of rst_n SHALL be synchronous to clock in the surrounding system; the block needs no internal synchronizer.

Structure
REQ-026 Package ram_ctrl_pkg SHALL hold the state enum (IDLE, WRITE, PRIME, READ) and the default ADDR_W/DATA_W constants.
REQ-027 There SHALL be no sub-module: ptr/cnt logic and the FSM live in ram_burst_ctrl.
REQ-028 The bench SHALL instantiate ram_burst_ctrl wired to the existing single-port RAM.

Verification
REQ-029 Write base=5 len=3 with data A0..A3 and wr_valid always high -> ram_we high for 4 cycles at addresses 5..8, then done one cycle later.
REQ-030 Read base=5 len=3 with rd_ready=1 -> rd_valid from accept+2, rd_data A0,A1,A2,A3 on consecutive cycles, then done.
REQ-031 Read as REQ-030 with rd_ready low for 3 cycles at beat 1 -> rd_data holds A1 throughout the stall; no beat is lost or duplicated.
REQ-032 Write base=62 len=3 of 11,22,33,44, then read back -> addresses 62,63,0,1, read data 11,22,33,44.
REQ-033 Write len=63 with wr_valid toggled every other cycle, then rst_n low mid-burst -> written prefix intact, no done, cmd_ready=1 after release.
REQ-034 cmd_valid held high during a busy burst -> exactly one command accepted per IDLE, and never in the done cycle.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
`default_nettype none
// ram_ctrl_pkg: shared types and default sizes for the RAM burst controller.
// Rev 1.0
package ram_ctrl_pkg;

  localparam int ADDR_W_DEFAULT = 6;
  localparam int DATA_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    PRIME = 2'd2,
    READ  = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/ram_burst_ctrl.sv
`default_nettype none
// ram_burst_ctrl: streams write/read bursts between valid/ready ports and a single-port RAM.
// Rev 1.0
module ram_burst_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              done,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic [ADDR_W-1:0] ptr_inc;

  assign ptr_inc = ptr_q + ADDR_ONE;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          ptr_d   = cmd_base;
          cnt_d   = cmd_len;
          state_d = cmd_write ? WRITE : PRIME;
        end
      end
      WRITE: begin
        if (wr_valid) begin
          ptr_d = ptr_inc;
          cnt_d = cnt_q - ADDR_ONE;
          if (cnt_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      PRIME: begin
        state_d = READ;
      end
      READ: begin
        if (rd_ready) begin
          ptr_d = ptr_inc;
          cnt_d = cnt_q - ADDR_ONE;
          if (cnt_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // The done cycle sits in IDLE but must refuse a new command.
    cmd_ready_d = (state_d == IDLE) && !done_d;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign done      = done_q;
  assign cmd_ready = cmd_ready_q;

  always_comb begin
    wr_ready = 1'b0;
    rd_valid = 1'b0;
    rd_data  = '0;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_data = '0;
    case (state_q)
      WRITE: begin
        wr_ready = 1'b1;
        ram_addr = ptr_q;
        ram_data = wr_data;
        ram_we   = wr_valid;
      end
      PRIME: begin
        ram_addr = ptr_q;
      end
      READ: begin
        rd_valid = 1'b1;
        rd_data  = ram_q;
        // Look ahead on a handshake; a stall re-reads the current word so rd_data holds.
        ram_addr = rd_ready ? ptr_inc : ptr_q;
      end
      default: begin
        ram_addr = '0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_burst_ctrl.sv
`default_nettype none
// tb_ram_burst_ctrl: directed table, corner sequences and random bursts against a memory model.
// Rev 1.0
module tb_ram_burst_ctrl;

  logic       clock = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [5:0] cmd_base, cmd_len;
  logic [7:0] wr_data;
  logic       wr_valid, wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid, rd_ready;
  logic       done;
  logic [7:0] ram_data;
  logic [5:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_q;

  always #5 clock = ~clock;

  ram_burst_ctrl #(.ADDR_W(6), .DATA_W(8)) dut (
    .clock(clock), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_base(cmd_base), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .done(done),
    .ram_data(ram_data), .ram_addr(ram_addr), .ram_we(ram_we), .ram_q(ram_q)
  );

  // Single-port RAM: write when we, otherwise register the addressed word.
  logic [7:0] ram_mem [64];
  always @(posedge clock) begin
    if (ram_we) ram_mem[ram_addr] <= ram_data;
    else        ram_q <= ram_mem[ram_addr];
  end

  logic [7:0] model_mem [64];
  int         touched [64];
  int         checks = 0;
  int         failures = 0;

  typedef struct {
    bit         wr;
    logic [5:0] base;
    logic [5:0] len;
    int         mode;
    logic [31:0] data;
    bit         use_data;
    int         exp_beats;
    logic [5:0] exp_last;
  } vec_t;

  vec_t tab [9];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0b required=%0b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chka(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    cmd_valid = 1'b0;
    while (!cmd_ready && n < 20) begin
      step();
      cmd_valid = 1'b0;
      #1;
      n++;
    end
    chk1("cmd_ready_wait", cmd_ready, 1'b1);
  endtask

  // mode: 0 wr_valid always, 1 random (plus stray commands), 2 toggle every other cycle
  task automatic do_write(input logic [5:0] base, input logic [5:0] len, input int mode,
                          input logic [31:0] tdata, input bit use_data, input int abort_at,
                          output int beats, output logic [5:0] last);
    int i, cyc;
    bit seen;
    logic [5:0] a;
    i = 0; cyc = 0; seen = 1'b0; last = '0;
    wait_ready();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_base = base; cmd_len = len;
    #1;
    while (!seen && cyc < 400) begin
      step();
      cyc++;
      cmd_valid = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      cmd_write = 1'($urandom); cmd_base = 6'($urandom); cmd_len = 6'($urandom);
      case (mode)
        0:       wr_valid = 1'b1;
        1:       wr_valid = ($urandom_range(0, 3) != 0);
        default: wr_valid = cyc[0];
      endcase
      wr_data  = (use_data && i < 4) ? tdata[8*(i&3) +: 8] : 8'($urandom);
      rd_ready = 1'($urandom);
      #1;
      if (done) begin
        seen = 1'b1;
        chk1("wdone_ram_we", ram_we, 1'b0);
        chk1("wdone_wr_ready", wr_ready, 1'b0);
        chk1("wdone_cmd_ready", cmd_ready, 1'b0);
      end else begin
        a = base + 6'(i);
        chk1("w_wr_ready", wr_ready, 1'b1);
        chk1("w_cmd_ready", cmd_ready, 1'b0);
        chk1("w_rd_valid", rd_valid, 1'b0);
        chk1("w_ram_we", ram_we, wr_valid);
        if (wr_valid) begin
          chka("w_ram_addr", ram_addr, a);
          chk8("w_ram_data", ram_data, wr_data);
          model_mem[a] = wr_data;
          touched[a]++;
          last = a;
          i++;
          if (abort_at >= 0 && i == abort_at) break;
        end
      end
    end
    beats = i;
    if (abort_at < 0) begin
      chk1("w_done_seen", seen, 1'b1);
      if (mode == 0) chki("w_cycles", cyc, int'(len) + 2);
      cmd_valid = 1'b0; wr_valid = 1'b0;
      step();
      #1;
      chk1("w_post_done", done, 1'b0);
      chk1("w_post_cmd_ready", cmd_ready, 1'b1);
    end
  endtask

  // mode: 0 rd_ready always, 1 random (plus stray commands), 2 three-cycle stall at beat 1
  task automatic do_read(input logic [5:0] base, input logic [5:0] len, input int mode,
                         input logic [31:0] tdata, input bit use_data,
                         output int beats, output logic [5:0] last);
    int i, cyc, stall;
    bit seen;
    logic [5:0] a;
    i = 0; cyc = 0; stall = 0; seen = 1'b0; last = '0;
    wait_ready();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_base = base; cmd_len = len;
    #1;
    step();
    cmd_valid = 1'b0; rd_ready = 1'($urandom); wr_valid = 1'($urandom);
    #1;
    chk1("prime_rd_valid", rd_valid, 1'b0);
    chk1("prime_ram_we", ram_we, 1'b0);
    chka("prime_ram_addr", ram_addr, base);
    chk1("prime_cmd_ready", cmd_ready, 1'b0);
    while (!seen && cyc < 400) begin
      step();
      cyc++;
      cmd_valid = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      cmd_write = 1'($urandom); cmd_base = 6'($urandom); cmd_len = 6'($urandom);
      wr_valid  = 1'($urandom);
      case (mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = ($urandom_range(0, 2) != 0);
        default: begin
          rd_ready = !(i == 1 && stall < 3);
          if (!rd_ready) stall++;
        end
      endcase
      #1;
      if (done) begin
        seen = 1'b1;
        chk1("rdone_rd_valid", rd_valid, 1'b0);
        chk1("rdone_cmd_ready", cmd_ready, 1'b0);
        chk1("rdone_ram_we", ram_we, 1'b0);
      end else begin
        a = base + 6'(i);
        chk1("r_rd_valid", rd_valid, 1'b1);
        chk1("r_ram_we", ram_we, 1'b0);
        chk1("r_cmd_ready", cmd_ready, 1'b0);
        chk8("r_rd_data", rd_data, model_mem[a]);
        if (use_data && i < 4) chk8("r_rd_data_tab", rd_data, tdata[8*(i&3) +: 8]);
        chka("r_ram_addr", ram_addr, rd_ready ? a + 6'd1 : a);
        if (rd_ready) begin
          last = a;
          i++;
        end
      end
    end
    beats = i;
    chk1("r_done_seen", seen, 1'b1);
    if (mode == 0) chki("r_cycles", cyc, int'(len) + 2);
    if (mode == 2 && len != 0) chki("r_stall_cycles", cyc, int'(len) + 5);
    cmd_valid = 1'b0; rd_ready = 1'b0;
    step();
    #1;
    chk1("r_post_done", done, 1'b0);
    chk1("r_post_cmd_ready", cmd_ready, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int beats, n1, accepts, dones, beat, cyc;
    logic [5:0] last, a;

    tab[0] = '{1'b1, 6'd5,  6'd3,  0, 32'hA3A2A1A0, 1'b1, 4,  6'd8};
    tab[1] = '{1'b0, 6'd5,  6'd3,  0, 32'hA3A2A1A0, 1'b1, 4,  6'd8};
    tab[2] = '{1'b0, 6'd5,  6'd3,  2, 32'hA3A2A1A0, 1'b1, 4,  6'd8};
    tab[3] = '{1'b1, 6'd62, 6'd3,  0, {8'd44, 8'd33, 8'd22, 8'd11}, 1'b1, 4, 6'd1};
    tab[4] = '{1'b0, 6'd62, 6'd3,  1, {8'd44, 8'd33, 8'd22, 8'd11}, 1'b1, 4, 6'd1};
    tab[5] = '{1'b1, 6'd0,  6'd0,  1, 32'h0000005A, 1'b1, 1,  6'd0};
    tab[6] = '{1'b0, 6'd0,  6'd0,  0, 32'h0000005A, 1'b1, 1,  6'd0};
    tab[7] = '{1'b1, 6'd40, 6'd63, 2, 32'h0,        1'b0, 64, 6'd39};
    tab[8] = '{1'b0, 6'd40, 6'd63, 1, 32'h0,        1'b0, 64, 6'd39};

    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_base = '0; cmd_len = '0;
    wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0;
    for (int k = 0; k < 64; k++) begin
      model_mem[k] = 8'h00;
      touched[k] = 0;
    end

    #3;
    chk1("rst_done", done, 1'b0);
    chk1("rst_wr_ready", wr_ready, 1'b0);
    chk1("rst_rd_valid", rd_valid, 1'b0);
    chk1("rst_ram_we", ram_we, 1'b0);
    chka("rst_ram_addr", ram_addr, 6'd0);
    chk8("rst_ram_data", ram_data, 8'h00);
    chk8("rst_rd_data", rd_data, 8'h00);
    @(negedge clock);
    rst_n = 1'b1;
    step();
    #1;
    chk1("rel_cmd_ready", cmd_ready, 1'b1);
    chk1("rel_done", done, 1'b0);

    // Full 64-beat wrap from a non-zero base; also initialises every RAM word.
    do_write(6'd9, 6'd63, 1, 32'h0, 1'b0, -1, beats, last);
    n1 = 0;
    for (int k = 0; k < 64; k++) if (touched[k] == 1) n1++;
    chki("fill_every_word_once", n1, 64);
    chki("fill_beats", beats, 64);

    for (int k = 0; k < 9; k++) begin
      if (tab[k].wr)
        do_write(tab[k].base, tab[k].len, tab[k].mode, tab[k].data, tab[k].use_data, -1, beats, last);
      else
        do_read(tab[k].base, tab[k].len, tab[k].mode, tab[k].data, tab[k].use_data, beats, last);
      chki("tab_beats", beats, tab[k].exp_beats);
      chka("tab_last_addr", last, tab[k].exp_last);
    end

    // cmd_valid held high across back-to-back write bursts.
    wait_ready();
    accepts = 0; dones = 0; beat = 0; cyc = 0;
    while (dones < 3 && cyc < 60) begin
      cmd_valid = (accepts < 3); cmd_write = 1'b1; cmd_base = 6'd30; cmd_len = 6'd2;
      wr_valid = 1'b1; wr_data = 8'($urandom);
      #1;
      if (cmd_valid && cmd_ready) accepts++;
      if (done) begin
        dones++;
        chk1("hold_done_cmd_ready", cmd_ready, 1'b0);
      end
      chk1("hold_ram_we", ram_we, wr_ready && wr_valid);
      if (wr_ready && wr_valid) begin
        a = 6'd30 + 6'(beat % 3);
        chka("hold_addr", ram_addr, a);
        model_mem[a] = wr_data;
        beat++;
      end
      cyc++;
      step();
    end
    cmd_valid = 1'b0; wr_valid = 1'b0;
    #1;
    chki("hold_accepts", accepts, 3);
    chki("hold_beats", beat, 9);
    chki("hold_cycles", cyc, 15);
    chk1("hold_final_ready", cmd_ready, 1'b1);

    // Long toggled write abandoned by reset after 10 beats; prefix must survive.
    do_write(6'd20, 6'd63, 2, 32'h0, 1'b0, 10, beats, last);
    step();
    wr_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk1("abort_done", done, 1'b0);
    chk1("abort_wr_ready", wr_ready, 1'b0);
    chk1("abort_ram_we", ram_we, 1'b0);
    chka("abort_ram_addr", ram_addr, 6'd0);
    chk8("abort_ram_data", ram_data, 8'h00);
    repeat (2) begin
      step();
      chk1("abort_hold_done", done, 1'b0);
    end
    @(negedge clock);
    rst_n = 1'b1;
    step();
    #1;
    chk1("abort_rel_cmd_ready", cmd_ready, 1'b1);
    chk1("abort_rel_done", done, 1'b0);
    do_read(6'd20, 6'd9, 0, 32'h0, 1'b0, beats, last);
    chki("abort_prefix_beats", beats, 10);

    for (int r = 0; r < 24; r++) begin
      logic [5:0] b, l;
      int m;
      b = 6'($urandom);
      l = ($urandom_range(0, 5) == 0) ? 6'd63 : 6'($urandom_range(0, 12));
      m = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1) do_write(b, l, m, 32'h0, 1'b0, -1, beats, last);
      else                           do_read(b, l, m, 32'h0, 1'b0, beats, last);
      chki("rand_beats", beats, int'(l) + 1);
      chka("rand_last_addr", last, b + l);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
